hm_tx: RTL and testbench
========================

Name: hm_tx

Overview:
- Request side of the host-memory read path: on a start pulse, builds one Memory Read request TLP (3 DW or 4 DW header, no payload) for a given address and length.
- Drives it onto the Xilinx V6 64-bit TRN transmit interface.
- Then waits for the completion-side receiver to report the last completion, or for a timeout.
- Sits beside the hm completion receiver and shares trn_clk with it.

Parameters:
- TIMEOUT_CYCLES, 16'hFFFF: trn_clk cycles allowed in WAIT before err is pulsed.

Ports:
- trn_clk  in  1  sole clock.
- sys_rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request strobe; sampled in IDLE only.
- hm_addr  in  64  byte address, latched on an accepted start; bits [1:0] are forced to 0.
- hm_len  in  10  DW count, latched on an accepted start; 0 means 1024.
- cfg_completer_id  in  16  requester ID, latched on an accepted start.
- rx_done  in  1  last-completion pulse from the completion receiver.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse: request completed.
- err  out  1  one-cycle pulse: timeout or link loss.
- trn_lnk_up_n  in  1  link status, active low.
- trn_tdst_rdy_n  in  1  core ready, active low.
- trn_tbuf_av  in  6  core buffer availability; bit 1 = non-posted.
- trn_td  out  64  TLP data.
- trn_trem_n  out  1  0 = all 8 bytes valid; 1 = only [63:32] valid.
- trn_tsof_n  out  1  start of frame.
- trn_teof_n  out  1  end of frame.
- trn_tsrc_rdy_n  out  1  source ready.
- trn_tsrc_dsc_n, trn_terrfwd_n, trn_tstr_n  out  1 each  tied to 1.
- stat_trn_cpt_tx  out  32  count of TLPs fully sent.
- stat_state  out  2  current state.

Behaviour:
- Reset values:
  - state = IDLE, tag = 0, stat_trn_cpt_tx = 0, timeout counter = 0.
  - busy = 0, done = 0, err = 0.
  - trn_td = 0, trn_trem_n = 1, trn_tsof_n = 1, trn_teof_n = 1, trn_tsrc_rdy_n = 1.
- Beat acceptance: a beat is accepted on a rising edge where trn_tsrc_rdy_n = 0 and trn_tdst_rdy_n = 0.
  - trn_td, trn_trem_n, trn_tsof_n and trn_teof_n are held stable until acceptance.
- Header fields:
  - Header format is 4 DW when latched addr[63:32] != 0, otherwise 3 DW.
  - DW0: fmt = 2'b00 (3 DW) or 2'b01 (4 DW); type = 5'b00000; TC/TD/EP/attr = 0; length = hm_len.
  - DW1: {requester ID, tag[7:0], last BE, first BE = 4'hF}.
  - Last BE = 4'h0 when hm_len == 1, else 4'hF.
- States, encoded IDLE = 0, SOF = 1, EOF = 2, WAIT = 3:
  - IDLE:
    - On start with trn_lnk_up_n = 0: latch the inputs, go to SOF, and from the next cycle drive beat0 = {DW0, DW1}, tsof_n = 0, tsrc_rdy_n = 0.
    - start while the link is down is dropped silently.
  - SOF:
    - On acceptance, go to EOF and drive beat1 with teof_n = 0, tsof_n = 1.
    - beat1 for 3 DW: {addr[31:2], 2'b00, 32'h0}, trem_n = 1.
    - beat1 for 4 DW: {addr[63:32], addr[31:2], 2'b00}, trem_n = 0.
    - The earliest EOF beat appears 2 cycles after start.
  - EOF:
    - On acceptance: tsrc_rdy_n = 1, stat_trn_cpt_tx += 1, tag += 1 (wraps 255 -> 0).
    - Clear the timeout counter and go to WAIT.
  - WAIT:
    - rx_done = 1 -> done pulse, go to IDLE.
    - Else if counter == TIMEOUT_CYCLES -> err pulse, go to IDLE.
    - Else counter += 1.
    - rx_done and timeout in the same cycle: rx_done wins.
- Boundary conditions:
  - trn_lnk_up_n = 1 while in SOF/EOF: drop tsrc_rdy_n/tsof_n/teof_n the next cycle, err pulse, go to IDLE; tag and stat are unchanged.
  - start while busy is ignored.
  - rx_done outside WAIT is ignored.
  - sys_rst in any state returns every output to its reset value on the next edge; a partial frame is abandoned.
- busy is asserted the cycle after an accepted start and deasserts with the done/err pulse.

Optional Feature:
- HM_TX_BUF_AV_EN defined: IDLE leaves for SOF only when start (or a start held pending since its strobe) coincides with trn_tbuf_av[1] = 1.
  - The pending start is held at most until the buffer frees; busy rises when the pending start is captured.
- HM_TX_BUF_AV_EN undefined: trn_tbuf_av is ignored and start proceeds immediately.

Test Plan:
- 3 DW request: start, hm_addr = 64'h0000_0000_1234_5678, hm_len = 16, id = 16'h0100, tdst_rdy_n = 0.
  - Beat0 = 64'h0000_0010_0100_00FF.
  - Beat1[63:32] = 32'h1234_5678, trem_n = 1.
  - stat = 1; rx_done 5 cycles later -> done pulse, busy = 0.
- 4 DW request with backpressure: hm_addr = 64'h0000_0001_0000_0004, hm_len = 1, tdst_rdy_n = 1 for 3 cycles.
  - Beat0 is held stable; DW0 fmt = 01; last BE = 0, first BE = F.
  - Beat1 = 64'h0000_0001_0000_0004, trem_n = 0.
- Timeout: TIMEOUT_CYCLES = 8 and no rx_done -> err pulses 9 cycles after EOF acceptance; state returns to IDLE.
- Tag and length wrap: 256 back-to-back requests with hm_len = 0 -> the tag wraps to 0 on the 257th request; DW0 length field = 0.
- Link loss: trn_lnk_up_n rises in SOF -> tsrc_rdy_n = 1 next cycle, err pulse, stat unchanged; start while the link is down -> no activity.
- Reset mid-frame plus simultaneous events: sys_rst during EOF -> all outputs at reset values.
  - Then rx_done coincident with timeout -> only done pulses.

Source files
------------

// File: rtl/hm_tx.sv
// hm_tx: request side of the host-memory read path.
//
// On an accepted start it builds one Memory Read request TLP (3 DW header
// when the upper address word is zero, otherwise 4 DW; no payload). It
// sends that TLP over the 64-bit TRN transmit interface, then waits for the
// completion receiver to report the last completion (rx_done). If that does
// not arrive in time, or the link drops while framing, it pulses err.
//
// Build option:
//   HM_TX_BUF_AV_EN  when defined, a request leaves IDLE only while
//                    trn_tbuf_av[1] (non-posted buffer) is set. A start that
//                    arrives while the buffer is full is held pending, and
//                    busy rises at capture. When undefined, trn_tbuf_av is
//                    ignored.
//
// Ports:
//   trn_clk, sys_rst        clock, synchronous active-high reset
//   start                   one-cycle request strobe (sampled in IDLE)
//   hm_addr, hm_len         byte address ([1:0] forced 0), DW count (0 = 1024)
//   cfg_completer_id        requester ID placed in DW1
//   rx_done                 last-completion pulse from the receiver
//   busy, done, err         status level / one-cycle pulses
//   trn_lnk_up_n, trn_tdst_rdy_n, trn_tbuf_av   TRN core status inputs
//   trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n  TRN tx beat
//   trn_tsrc_dsc_n, trn_terrfwd_n, trn_tstr_n   tied inactive
//   stat_trn_cpt_tx         count of TLPs fully sent
//   stat_state              current FSM state
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no request in flight (may hold a pending start with buf-av gating)
// SOF   | header beat 0 {DW0, DW1} presented, waiting for acceptance
// EOF   | header beat 1 (address) presented, waiting for acceptance
// WAIT  | TLP sent; waiting for rx_done or the timeout counter to expire

module hm_tx #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
   input  logic        trn_clk,
   input  logic        sys_rst,
   input  logic        start,
   input  logic [63:0] hm_addr,
   input  logic [9:0]  hm_len,
   input  logic [15:0] cfg_completer_id,
   input  logic        rx_done,
   output logic        busy,
   output logic        done,
   output logic        err,
   input  logic        trn_lnk_up_n,
   input  logic        trn_tdst_rdy_n,
   input  logic [5:0]  trn_tbuf_av,
   output logic [63:0] trn_td,
   output logic        trn_trem_n,
   output logic        trn_tsof_n,
   output logic        trn_teof_n,
   output logic        trn_tsrc_rdy_n,
   output logic        trn_tsrc_dsc_n,
   output logic        trn_terrfwd_n,
   output logic        trn_tstr_n,
   output logic [31:0] stat_trn_cpt_tx,
   output logic [1:0]  stat_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SOF  = 2'd1,
      S_EOF  = 2'd2,
      S_WAIT = 2'd3
   } state_t;

   state_t      state;
   logic [7:0]  tag;
   logic [63:2] addr_q;
   logic        four_dw_q;
   logic [15:0] tmo_cnt;

`ifdef HM_TX_BUF_AV_EN
   logic        pend;
   logic [9:0]  len_q;
   logic [15:0] id_q;
`endif

   logic [63:2] launch_addr;
   logic [9:0]  launch_len;
   logic [15:0] launch_id;
   logic        launch_four;
   logic [63:0] beat0;
   logic [63:0] beat1;
   logic        accept;
   logic        unused_bits;

   assign trn_tsrc_dsc_n = 1'b1;
   assign trn_terrfwd_n  = 1'b1;
   assign trn_tstr_n     = 1'b1;
   assign stat_state     = state;

   assign accept = !trn_tsrc_rdy_n && !trn_tdst_rdy_n;

`ifdef HM_TX_BUF_AV_EN
   assign unused_bits = ^{hm_addr[1:0], trn_tbuf_av[5:2], trn_tbuf_av[0]};
`else
   assign unused_bits = ^{hm_addr[1:0], trn_tbuf_av};
`endif

   // A pending start launches from its captured fields; otherwise the
   // header is built straight from the inputs so beat 0 appears one cycle
   // after the strobe.
   always_comb begin
      launch_addr = hm_addr[63:2];
      launch_len  = hm_len;
      launch_id   = cfg_completer_id;
`ifdef HM_TX_BUF_AV_EN
      if (pend) begin
         launch_addr = addr_q;
         launch_len  = len_q;
         launch_id   = id_q;
      end
`endif
   end

   assign launch_four = |launch_addr[63:32];

   // DW0: fmt in [30:29], type/TC/TD/EP/attr all zero, length in [9:0].
   // DW1: requester ID, tag, last BE (0 for single-DW reads), first BE.
   assign beat0 = {1'b0, 1'b0, launch_four, 5'b00000, 14'd0, launch_len,
                   launch_id, tag, (launch_len == 10'd1) ? 4'h0 : 4'hF, 4'hF};

   assign beat1 = four_dw_q ? {addr_q[63:32], addr_q[31:2], 2'b00}
                            : {addr_q[31:2], 2'b00, 32'h0000_0000};

   always_ff @(posedge trn_clk) begin
      if (sys_rst) begin
         state           <= S_IDLE;
         tag             <= 8'd0;
         addr_q          <= '0;
         four_dw_q       <= 1'b0;
         tmo_cnt         <= 16'd0;
         stat_trn_cpt_tx <= 32'd0;
         busy            <= 1'b0;
         done            <= 1'b0;
         err             <= 1'b0;
         trn_td          <= 64'd0;
         trn_trem_n      <= 1'b1;
         trn_tsof_n      <= 1'b1;
         trn_teof_n      <= 1'b1;
         trn_tsrc_rdy_n  <= 1'b1;
`ifdef HM_TX_BUF_AV_EN
         pend            <= 1'b0;
         len_q           <= 10'd0;
         id_q            <= 16'd0;
`endif
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            S_IDLE: begin
`ifdef HM_TX_BUF_AV_EN
               if (pend) begin
                  if (trn_lnk_up_n) begin
                     pend <= 1'b0;
                     busy <= 1'b0;
                     err  <= 1'b1;
                  end else if (trn_tbuf_av[1]) begin
                     pend           <= 1'b0;
                     four_dw_q      <= launch_four;
                     state          <= S_SOF;
                     trn_td         <= beat0;
                     trn_trem_n     <= 1'b0;
                     trn_tsof_n     <= 1'b0;
                     trn_teof_n     <= 1'b1;
                     trn_tsrc_rdy_n <= 1'b0;
                  end
               end else if (start && !trn_lnk_up_n) begin
                  addr_q    <= launch_addr;
                  len_q     <= launch_len;
                  id_q      <= launch_id;
                  four_dw_q <= launch_four;
                  busy      <= 1'b1;
                  if (trn_tbuf_av[1]) begin
                     state          <= S_SOF;
                     trn_td         <= beat0;
                     trn_trem_n     <= 1'b0;
                     trn_tsof_n     <= 1'b0;
                     trn_teof_n     <= 1'b1;
                     trn_tsrc_rdy_n <= 1'b0;
                  end else begin
                     pend <= 1'b1;
                  end
               end
`else
               if (start && !trn_lnk_up_n) begin
                  addr_q         <= launch_addr;
                  four_dw_q      <= launch_four;
                  busy           <= 1'b1;
                  state          <= S_SOF;
                  trn_td         <= beat0;
                  trn_trem_n     <= 1'b0;
                  trn_tsof_n     <= 1'b0;
                  trn_teof_n     <= 1'b1;
                  trn_tsrc_rdy_n <= 1'b0;
               end
`endif
            end
            S_SOF: begin
               if (trn_lnk_up_n) begin
                  trn_tsrc_rdy_n <= 1'b1;
                  trn_tsof_n     <= 1'b1;
                  trn_teof_n     <= 1'b1;
                  err            <= 1'b1;
                  busy           <= 1'b0;
                  state          <= S_IDLE;
               end else if (accept) begin
                  trn_td     <= beat1;
                  trn_trem_n <= ~four_dw_q;
                  trn_tsof_n <= 1'b1;
                  trn_teof_n <= 1'b0;
                  state      <= S_EOF;
               end
            end
            S_EOF: begin
               if (trn_lnk_up_n) begin
                  trn_tsrc_rdy_n <= 1'b1;
                  trn_tsof_n     <= 1'b1;
                  trn_teof_n     <= 1'b1;
                  err            <= 1'b1;
                  busy           <= 1'b0;
                  state          <= S_IDLE;
               end else if (accept) begin
                  trn_tsrc_rdy_n  <= 1'b1;
                  trn_teof_n      <= 1'b1;
                  stat_trn_cpt_tx <= stat_trn_cpt_tx + 32'd1;
                  tag             <= tag + 8'd1;
                  tmo_cnt         <= TIMEOUT_CYCLES;
                  state           <= S_WAIT;
               end
            end
            S_WAIT: begin
               // Down-counter loaded with TIMEOUT_CYCLES: err fires on the
               // (TIMEOUT_CYCLES+1)-th WAIT cycle; rx_done has priority.
               if (rx_done) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else if (tmo_cnt == 16'd0) begin
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt - 16'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hm_tx.sv
module tb_hm_tx;

   logic        trn_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        start = 1'b0;
   logic [63:0] hm_addr = 64'd0;
   logic [9:0]  hm_len = 10'd0;
   logic [15:0] cfg_completer_id = 16'd0;
   logic        rx_done = 1'b0;
   logic        trn_lnk_up_n = 1'b0;
   logic        trn_tdst_rdy_n = 1'b0;
   logic [5:0]  trn_tbuf_av = 6'h3F;
   logic        busy, done, err;
   logic [63:0] trn_td;
   logic        trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n;
   logic        trn_tsrc_dsc_n, trn_terrfwd_n, trn_tstr_n;
   logic [31:0] stat_trn_cpt_tx;
   logic [1:0]  stat_state;

   hm_tx #(.TIMEOUT_CYCLES(16'd8)) dut (
      .trn_clk(trn_clk), .sys_rst(sys_rst), .start(start), .hm_addr(hm_addr),
      .hm_len(hm_len), .cfg_completer_id(cfg_completer_id), .rx_done(rx_done),
      .busy(busy), .done(done), .err(err), .trn_lnk_up_n(trn_lnk_up_n),
      .trn_tdst_rdy_n(trn_tdst_rdy_n), .trn_tbuf_av(trn_tbuf_av),
      .trn_td(trn_td), .trn_trem_n(trn_trem_n), .trn_tsof_n(trn_tsof_n),
      .trn_teof_n(trn_teof_n), .trn_tsrc_rdy_n(trn_tsrc_rdy_n),
      .trn_tsrc_dsc_n(trn_tsrc_dsc_n), .trn_terrfwd_n(trn_terrfwd_n),
      .trn_tstr_n(trn_tstr_n), .stat_trn_cpt_tx(stat_trn_cpt_tx),
      .stat_state(stat_state)
   );

   always #5 trn_clk = ~trn_clk;

   typedef struct {
      logic [63:0] td;
      logic        rem;
      logic        sof;
   } beat_t;

   beat_t      sb[$];
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         eof_cyc = 0;
   logic [7:0] exp_tag = 8'd0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   always @(posedge trn_clk) cyc <= cyc + 1;

   // Scoreboard: a beat presented at the negedge with tdst_rdy_n low is taken
   // on the next rising edge (inputs only change just after rising edges).
   always @(negedge trn_clk) begin
      beat_t b;
      if (!trn_tsrc_rdy_n && sb.size() > 0) begin
         if (!trn_tdst_rdy_n) begin
            b = sb.pop_front();
            check_val("beat_td", trn_td, b.td);
            check_val("beat_tsof_n", trn_tsof_n, !b.sof);
            check_val("beat_teof_n", trn_teof_n, b.sof);
            if (!b.sof) begin
               check_val("beat_trem_n", trn_trem_n, b.rem);
               eof_cyc = cyc + 1;
            end
         end else begin
            check_val("hold_td", trn_td, sb[0].td);
         end
      end else if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
         check_val("extra_beat", trn_tsrc_rdy_n, 1);
      end
   end

   task automatic tick();
      @(posedge trn_clk);
      #1;
   endtask

   function automatic logic [63:0] model_b0(input logic [63:0] a, input logic [9:0] l,
                                            input logic [15:0] id, input logic [7:0] t);
      logic four;
      four = (a[63:32] != 32'd0);
      return {1'b0, 1'b0, four, 5'b00000, 14'd0, l, id, t, (l == 10'd1) ? 4'h0 : 4'hF, 4'hF};
   endfunction

   task automatic push_beats(input logic [63:0] b0, input logic [63:0] b1, input logic rem);
      beat_t b;
      b.td = b0; b.rem = 1'b0; b.sof = 1'b1;
      sb.push_back(b);
      b.td = b1; b.rem = rem; b.sof = 1'b0;
      sb.push_back(b);
      exp_tag++;
   endtask

   task automatic push_model(input logic [63:0] a, input logic [9:0] l, input logic [15:0] id);
      logic [63:0] b1;
      logic        four;
      four = (a[63:32] != 32'd0);
      b1 = four ? {a[63:32], a[31:2], 2'b00} : {a[31:2], 2'b00, 32'd0};
      push_beats(model_b0(a, l, id, exp_tag), b1, !four);
   endtask

   task automatic pulse_start(input logic [63:0] a, input logic [9:0] l, input logic [15:0] id);
      hm_addr = a; hm_len = l; cfg_completer_id = id;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_state(input logic [1:0] s, input string tag);
      int n;
      n = 0;
      while (stat_state !== s && n < 60) begin
         tick();
         n++;
      end
      check_val(tag, stat_state, s);
   endtask

   task automatic finish_req(input int gap);
      wait_state(2'd3, "reach_wait");
      repeat (gap) tick();
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      check_val("done_pulse", done, 1);
      check_val("busy_after_done", busy, 0);
   endtask

   task automatic check_reset_vals(input string pfx);
      check_val({pfx, "_busy"}, busy, 0);
      check_val({pfx, "_done"}, done, 0);
      check_val({pfx, "_err"}, err, 0);
      check_val({pfx, "_td"}, trn_td, 64'd0);
      check_val({pfx, "_trem_n"}, trn_trem_n, 1);
      check_val({pfx, "_tsof_n"}, trn_tsof_n, 1);
      check_val({pfx, "_teof_n"}, trn_teof_n, 1);
      check_val({pfx, "_tsrc_rdy_n"}, trn_tsrc_rdy_n, 1);
      check_val({pfx, "_stat"}, stat_trn_cpt_tx, 0);
      check_val({pfx, "_state"}, stat_state, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [31:0] stat_before;

      // reset state and tie-offs
      tick(); tick();
      check_reset_vals("rst");
      check_val("tie_offs", {trn_tsrc_dsc_n, trn_terrfwd_n, trn_tstr_n}, 3'b111);
      sys_rst = 1'b0;
      tick();

      // rx_done outside WAIT is ignored
      rx_done = 1'b1; tick(); rx_done = 1'b0;
      check_val("rx_done_idle", {done, busy}, 2'b00);

      // 3 DW request
      push_beats(64'h0000_0010_0100_00FF, 64'h1234_5678_0000_0000, 1'b1);
      pulse_start(64'h0000_0000_1234_5678, 10'd16, 16'h0100);
      check_val("busy_after_start", busy, 1);
      wait_state(2'd3, "t1_wait");
      check_val("t1_stat", stat_trn_cpt_tx, 1);
      pulse_start(64'h0000_0000_0000_0040, 10'd4, 16'h0100);   // ignored while busy
      check_val("start_busy_ignored", stat_state, 3);
      finish_req(4);
      tick();
      check_val("done_one_shot", done, 0);

      // 4 DW request with 3 cycles of backpressure on beat 0
      trn_tdst_rdy_n = 1'b1;
      push_beats(64'h2000_0001_0100_010F, 64'h0000_0001_0000_0004, 1'b0);
      pulse_start(64'h0000_0001_0000_0004, 10'd1, 16'h0100);
      repeat (3) tick();
      check_val("t2_held_in_sof", stat_state, 1);
      trn_tdst_rdy_n = 1'b0;
      finish_req(2);

      // timeout: err on the 9th cycle after EOF acceptance
      push_model(64'h0000_0000_0000_2000, 10'd8, 16'h0200);
      pulse_start(64'h0000_0000_0000_2000, 10'd8, 16'h0200);
      wait_state(2'd3, "t3_wait");
      n = 0;
      while (err !== 1'b1 && n < 30) begin tick(); n++; end
      check_val("t3_err", err, 1);
      check_val("t3_err_delay", cyc - eof_cyc, 9);
      check_val("t3_state", stat_state, 0);
      check_val("t3_busy", busy, 0);
      tick();
      check_val("t3_err_one_shot", err, 0);

      // link loss in SOF, then start while link is down
      stat_before = stat_trn_cpt_tx;
      trn_tdst_rdy_n = 1'b1;
      pulse_start(64'h0000_0000_0000_3000, 10'd2, 16'h0300);
      check_val("ll_in_sof", stat_state, 1);
      trn_lnk_up_n = 1'b1;
      tick();
      check_val("ll_tsrc_rdy_n", trn_tsrc_rdy_n, 1);
      check_val("ll_tsof_n", trn_tsof_n, 1);
      check_val("ll_err", err, 1);
      check_val("ll_state", stat_state, 0);
      check_val("ll_stat", stat_trn_cpt_tx, stat_before);
      pulse_start(64'h0000_0000_0000_3000, 10'd2, 16'h0300);
      tick();
      check_val("ll_down_start", {busy, trn_tsrc_rdy_n, stat_state}, 4'b0100);
      trn_lnk_up_n = 1'b0;
      trn_tdst_rdy_n = 1'b0;
      tick();
      // tag must be unchanged by the aborted frame
      push_model(64'h0000_0000_0000_4000, 10'd3, 16'h0400);
      pulse_start(64'h0000_0000_0000_4000, 10'd3, 16'h0400);
      finish_req(1);

      // tag wrap: 257 requests from reset, hm_len = 0
      sys_rst = 1'b1; tick(); sys_rst = 1'b0;
      sb.delete(); exp_tag = 8'd0;
      tick();
      for (int i = 0; i < 257; i++) begin
         push_model(64'h0000_0000_0001_0000 + 64'(i * 8), 10'd0, 16'hABCD);
         pulse_start(64'h0000_0000_0001_0000 + 64'(i * 8), 10'd0, 16'hABCD);
         wait_state(2'd3, "wrap_wait");
         rx_done = 1'b1; tick(); rx_done = 1'b0;
      end
      check_val("wrap_stat", stat_trn_cpt_tx, 257);
      check_val("wrap_sb_empty", sb.size(), 0);

      // reset during EOF
      trn_tdst_rdy_n = 1'b1;
      push_model(64'h0000_0005_0000_0100, 10'd7, 16'h0500);
      pulse_start(64'h0000_0005_0000_0100, 10'd7, 16'h0500);
      trn_tdst_rdy_n = 1'b0;
      tick();
      trn_tdst_rdy_n = 1'b1;
      check_val("mr_in_eof", stat_state, 2);
      sys_rst = 1'b1;
      tick();
      check_reset_vals("mr");
      sys_rst = 1'b0;
      sb.delete(); exp_tag = 8'd0;
      trn_tdst_rdy_n = 1'b0;
      tick();

      // rx_done coincident with timeout expiry: done wins
      push_model(64'h0000_0000_0000_6000, 10'd5, 16'h0600);
      pulse_start(64'h0000_0000_0000_6000, 10'd5, 16'h0600);
      wait_state(2'd3, "co_wait");
      n = 0;
      while (cyc < eof_cyc + 8 && n < 40) begin tick(); n++; end
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      check_val("co_done", done, 1);
      check_val("co_err", err, 0);
      check_val("co_state", stat_state, 0);
      tick();
      check_val("co_err_after", err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
